// File: rtl/motion_pkg.sv
// Shared types and default widths for the motion move sequencer and its skid buffer.
package motion_pkg;

    localparam int NUM_W_DEF    = 16;
    localparam int WIDTH_W_DEF  = 16;
    localparam int CNT_W_DEF    = 16;
    localparam int START_TO_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TRIG,
        ST_RUN,
        ST_DONE
    } MotionSeq_state;

    typedef struct packed {
        logic [NUM_W_DEF-1:0]   num_x;
        logic [NUM_W_DEF-1:0]   num_y;
        logic [WIDTH_W_DEF-1:0] width_x;
        logic [WIDTH_W_DEF-1:0] width_y;
        logic                   dir_x;
        logic                   dir_y;
    } move_cmd_t;

endpackage

// File: rtl/motion_move_skid.sv
// One-entry holding buffer for a move command accepted while the sequencer is busy.
module motion_move_skid
    import motion_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  move_cmd_t push_data,
    input  logic      pop,
    output logic      full,
    output move_cmd_t data
);

    // A push in the same cycle as a pop refills the entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (push) begin
            full <= 1'b1;
            data <= push_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/motion_move_sequencer.sv
// Sequences the X/Y stepper controllers for one move command at a time.
// Optional one-entry command skid buffer enabled by MOTION_MOVE_SEQ_SKID_EN.
//
// state | meaning
// IDLE  | waiting for a command
// LOAD  | command latched onto step_*, decide which axes are active
// TRIG  | trigger active axes until each has reported working
// RUN   | wait for all active axes to stop working
// DONE  | move finished, count it (unless start error)
module motion_move_sequencer
    import motion_pkg::*;
#(
    parameter int NUM_W    = NUM_W_DEF,
    parameter int WIDTH_W  = WIDTH_W_DEF,
    parameter int START_TO = START_TO_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [NUM_W-1:0]   cmd_num_x,
    input  logic [NUM_W-1:0]   cmd_num_y,
    input  logic [WIDTH_W-1:0] cmd_width_x,
    input  logic [WIDTH_W-1:0] cmd_width_y,
    input  logic               cmd_dir_x,
    input  logic               cmd_dir_y,
    output logic [NUM_W-1:0]   step_num_x,
    output logic [NUM_W-1:0]   step_num_y,
    output logic [WIDTH_W-1:0] step_width_x,
    output logic [WIDTH_W-1:0] step_width_y,
    output logic               step_dir_x,
    output logic               step_dir_y,
    output logic               trigger_x,
    output logic               trigger_y,
    input  logic               working_x,
    input  logic               working_y,
    output logic               busy,
    output logic               move_done,
    output logic               start_err,
    output logic [CNT_W-1:0]   move_count
);

    localparam int TO_W = $clog2(START_TO + 1);

    MotionSeq_state  state, state_nx;
    move_cmd_t       cmd_in, load_cmd;
    logic            hs, load_go, timeout;
    logic            act_x, act_y, seen_x, seen_y, seen_x_nx, seen_y_nx, err_flag;
    logic [TO_W-1:0] to_cnt;

    always_comb begin
        cmd_in         = '0;
        cmd_in.num_x   = cmd_num_x;
        cmd_in.num_y   = cmd_num_y;
        cmd_in.width_x = cmd_width_x;
        cmd_in.width_y = cmd_width_y;
        cmd_in.dir_x   = cmd_dir_x;
        cmd_in.dir_y   = cmd_dir_y;
    end

`ifdef MOTION_MOVE_SEQ_SKID_EN
    logic      skid_full, push, pop;
    move_cmd_t skid_data;

    // In IDLE with an empty buffer the command bypasses the skid straight into step_*.
    assign cmd_ready = ~skid_full;
    assign push      = hs & (state != ST_IDLE);
    assign load_cmd  = pop ? skid_data : cmd_in;

    motion_move_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (cmd_in),
        .pop       (pop),
        .full      (skid_full),
        .data      (skid_data)
    );
`else
    assign cmd_ready = (state == ST_IDLE);
    assign load_cmd  = cmd_in;
`endif

    assign hs = cmd_valid & cmd_ready;

    // Working is sampled every tick so a one-tick pulse from a zero-width axis is caught.
    assign seen_x_nx = seen_x | (clk_en & act_x & working_x);
    assign seen_y_nx = seen_y | (clk_en & act_y & working_y);

    always_comb begin
        state_nx = state;
        load_go  = 1'b0;
        timeout  = 1'b0;
`ifdef MOTION_MOVE_SEQ_SKID_EN
        pop      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
`ifdef MOTION_MOVE_SEQ_SKID_EN
                if (skid_full) begin
                    pop      = 1'b1;
                    load_go  = 1'b1;
                    state_nx = ST_LOAD;
                end else if (hs) begin
                    load_go  = 1'b1;
                    state_nx = ST_LOAD;
                end
`else
                if (hs) begin
                    load_go  = 1'b1;
                    state_nx = ST_LOAD;
                end
`endif
            end
            ST_LOAD: begin
                if ((step_num_x == '0) && (step_num_y == '0)) state_nx = ST_DONE;
                else                                          state_nx = ST_TRIG;
            end
            ST_TRIG: begin
                if ((seen_x_nx | ~act_x) & (seen_y_nx | ~act_y)) begin
                    state_nx = ST_RUN;
                end else if (clk_en && (to_cnt == TO_W'(1))) begin
                    timeout  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_RUN: begin
                if (clk_en & ~(act_x & working_x) & ~(act_y & working_y)) state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
`ifdef MOTION_MOVE_SEQ_SKID_EN
                if (skid_full) begin
                    pop      = 1'b1;
                    load_go  = 1'b1;
                    state_nx = ST_LOAD;
                end
`endif
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign trigger_x = (state == ST_TRIG) & act_x & ~seen_x;
    assign trigger_y = (state == ST_TRIG) & act_y & ~seen_y;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            step_num_x   <= '0;
            step_num_y   <= '0;
            step_width_x <= '0;
            step_width_y <= '0;
            step_dir_x   <= 1'b0;
            step_dir_y   <= 1'b0;
            act_x        <= 1'b0;
            act_y        <= 1'b0;
            seen_x       <= 1'b0;
            seen_y       <= 1'b0;
            err_flag     <= 1'b0;
            to_cnt       <= '0;
            move_done    <= 1'b0;
            start_err    <= 1'b0;
            move_count   <= '0;
        end else begin
            state     <= state_nx;
            move_done <= (state == ST_DONE);
            start_err <= timeout;
            if (load_go) begin
                step_num_x   <= load_cmd.num_x;
                step_num_y   <= load_cmd.num_y;
                step_width_x <= load_cmd.width_x;
                step_width_y <= load_cmd.width_y;
                step_dir_x   <= load_cmd.dir_x;
                step_dir_y   <= load_cmd.dir_y;
            end
            if (state == ST_LOAD) begin
                act_x    <= (step_num_x != '0);
                act_y    <= (step_num_y != '0);
                seen_x   <= 1'b0;
                seen_y   <= 1'b0;
                err_flag <= 1'b0;
                to_cnt   <= TO_W'(START_TO);
            end
            if (state == ST_TRIG) begin
                seen_x <= seen_x_nx;
                seen_y <= seen_y_nx;
                if (clk_en) to_cnt <= to_cnt - 1'b1;
            end
            if (timeout) err_flag <= 1'b1;
            if ((state == ST_DONE) && !err_flag) move_count <= move_count + CNT_W'(1);
        end
    end

endmodule
